// File: rtl/riscv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width, M-op funct3
// codes and the iterative unit's state encoding.
package riscv_pkg;

    localparam int unsigned DefaultWidth = 32;

    localparam logic [2:0] Funct3Mul    = 3'b000;
    localparam logic [2:0] Funct3Mulh   = 3'b001;
    localparam logic [2:0] Funct3Mulhsu = 3'b010;
    localparam logic [2:0] Funct3Mulhu  = 3'b011;
    localparam logic [2:0] Funct3Div    = 3'b100;
    localparam logic [2:0] Funct3Divu   = 3'b101;
    localparam logic [2:0] Funct3Rem    = 3'b110;
    localparam logic [2:0] Funct3Remu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = riscv_pkg::DefaultWidth
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, SrcA, SrcB, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, SrcA, SrcB, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract if it fits.
// Only built when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module muldiv_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor holds on entry, so diff's top bit is a clean borrow flag.
    always_comb begin
        shifted  = {rem, in_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule
`endif

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Divider and its special cases are built only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    muldiv_state_e      state_q;
    logic [2:0]         op_q;
    logic               sign_a_q, sign_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;
    logic [CntW-1:0]    cnt_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   result_q;

    logic               in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               special;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, acc_next, prod_fix;
    logic [WIDTH-1:0]   mul_res, calc_res;

    always_comb begin
        in_sign_a = (bus.funct3 inside {Funct3Mulh, Funct3Mulhsu, Funct3Div, Funct3Rem})
                    & bus.SrcA[WIDTH-1];
        in_sign_b = (bus.funct3 inside {Funct3Mulh, Funct3Div, Funct3Rem}) & bus.SrcB[WIDTH-1];
        abs_a     = in_sign_a ? -bus.SrcA : bus.SrcA;
        abs_b     = in_sign_b ? -bus.SrcB : bus.SrcB;
    end

    // Multiplier sits in the low half and shifts out LSB-first as the product grows above it.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod_fix = (sign_a_q ^ sign_b_q) ? -mul_next : mul_next;
        mul_res  = (op_q == Funct3Mul) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end

`ifdef MULDIV_DIV_EN
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] rem_next, quo, rem, div_res;
    logic             q_bit;

    muldiv_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem     (acc_q[2*WIDTH-1:WIDTH]),
        .in_bit  (acc_q[WIDTH-1]),
        .divisor (opb_q),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        acc_next = op_q[2] ? {rem_next, acc_q[WIDTH-2:0], q_bit} : mul_next;
        quo      = acc_next[WIDTH-1:0];
        rem      = acc_next[2*WIDTH-1:WIDTH];
        unique case (op_q)
            Funct3Div:  div_res = (sign_a_q ^ sign_b_q) ? -quo : quo;
            Funct3Rem:  div_res = sign_a_q ? -rem : rem;
            Funct3Remu: div_res = rem;
            default:    div_res = quo;
        endcase
        calc_res = op_q[2] ? div_res : mul_res;
    end

    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (bus.funct3[2]) begin
            if (bus.SrcB == '0) begin
                special     = 1'b1;
                special_res = bus.funct3[1] ? bus.SrcA : '1;
            end else if (!bus.funct3[0] && bus.SrcA == MinNeg && bus.SrcB == '1) begin
                special     = 1'b1;
                special_res = bus.funct3[1] ? '0 : MinNeg;
            end
        end
    end
`else
    // Without the divider every divide/remainder op completes at once with a zero result.
    always_comb begin
        acc_next    = mul_next;
        calc_res    = mul_res;
        special     = bus.funct3[2];
        special_res = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.flush) begin
                        op_q     <= bus.funct3;
                        sign_a_q <= in_sign_a;
                        sign_b_q <= in_sign_b;
                        cnt_q    <= CntW'(WIDTH - 1);
                        acc_q    <= {{WIDTH{1'b0}}, bus.funct3[2] ? abs_a : abs_b};
                        opb_q    <= bus.funct3[2] ? abs_b : abs_a;
                        if (special) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state_q <= StCalc;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q  <= StDone;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= calc_res;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: fixed vector table, multi-cycle corner sequences and random ops
// checked against an arithmetic reference model. Honours MULDIV_DIV_EN like the design.
module tb_muldiv_unit;
    import riscv_pkg::*;

    localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0:    p = ua * ub;
            3'd1:    p = sa * sb;
            3'd2:    p = sa * longint'(ub);
            3'd3:    p = ua * ub;
            default: p = '0;
        endcase
        if (f3 == 3'd0) return p[31:0];
        if (!f3[2]) return p[63:32];
        if (!DivEn) return 32'h0;
        if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'h0 : 32'h8000_0000;
        case (f3)
            3'd4:    p = 64'(sa / sb);
            3'd5:    p = ua / ub;
            3'd6:    p = 64'(sa % sb);
            default: p = ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!f3[2]) return 33;
        if (!DivEn) return 1;
        if (b == 32'h0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
        tbl.push_back(v);
    endtask

    // sync=0 means the caller is already at a negedge; hold keeps start high (with new
    // operands) while the op runs, which the unit must ignore.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name,
                          input bit sync, input bit hold);
        int lat;
        int busy_n;
        if (sync) @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b0;
        bus.funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
        @(posedge clk);
        #1;
        if (hold) begin
            bus.funct3 = ~f3;
            bus.SrcA   = ~a;
            bus.SrcB   = a ^ b ^ 32'h1234_5678;
        end else begin
            bus.start = 1'b0;
        end
        lat    = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
        end while (!bus.done && lat < 100);
        bus.start = 1'b0;
        check({name, " result"}, bus.result, exp);
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy cycles"}, busy_n, (exp_lat == 33) ? 32 : 0);
        last_exp = exp;
        @(negedge clk);
        check({name, " done pulse"}, bus.done, 1'b0);
        check({name, " result hold"}, bus.result, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        logic [2:0]  f3;
        logic [31:0] a, b;

        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.SrcA   = '0;
        bus.SrcB   = '0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset result", bus.result, 32'h0);
        reset = 1'b1;

        add(Funct3Mul,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul 7*-3");
        add(Funct3Mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu max");
        add(Funct3Mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh -1*-1");
        add(Funct3Mulhsu, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu -1*2");
        add(Funct3Mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh min*min");
        add(Funct3Mulhu,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, "mulhu 2^32");
        add(Funct3Div,  32'hFFFF_FFEC, 32'd3, DivEn ? 32'hFFFF_FFFA : 32'h0, DivEn ? 33 : 1,
            "div -20/3");
        add(Funct3Rem,  32'hFFFF_FFEC, 32'd3, DivEn ? 32'hFFFF_FFFE : 32'h0, DivEn ? 33 : 1,
            "rem -20/3");
        add(Funct3Divu, 32'd20, 32'd3, DivEn ? 32'd6 : 32'h0, DivEn ? 33 : 1, "divu 20/3");
        add(Funct3Div,  32'd5, 32'd0, DivEn ? 32'hFFFF_FFFF : 32'h0, 1, "div 5/0");
        add(Funct3Remu, 32'd7, 32'd0, DivEn ? 32'd7 : 32'h0, 1, "remu 7/0");
        add(Funct3Rem,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem ovf");
        add(Funct3Div,  32'h8000_0000, 32'hFFFF_FFFF, DivEn ? 32'h8000_0000 : 32'h0, 1,
            "div ovf");

        foreach (tbl[i])
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].name,
                   1'b1, 1'b0);

        // start held high through the op with changing operands must not restart it
        run_op(Funct3Mul, 32'd1234, 32'd5678, 32'd7006652, 33, "held start", 1'b1, 1'b1);

        // flush in CALC cycle 10, then a new op presented in the very next cycle
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = Funct3Mul;
        bus.SrcA   = 32'd123;
        bus.SrcB   = 32'd456;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("flush pre busy", bus.busy, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", bus.busy, 1'b0);
        check("flush done", bus.done, 1'b0);
        check("flush result", bus.result, last_exp);
        run_op(Funct3Mul, 32'd9, 32'd11, 32'd99, 33, "post-flush", 1'b0, 1'b0);

        // start and flush together in IDLE: nothing accepted
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = Funct3Mul;
        bus.SrcA   = 32'd5;
        bus.SrcB   = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("idle flush busy", bus.busy, 1'b0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("idle flush done count", dn, 0);
        check("idle flush result", bus.result, last_exp);

        // reset in CALC cycle 5
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = Funct3Mulhu;
        bus.SrcA   = 32'hFFFF_FFFF;
        bus.SrcB   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid reset busy", bus.busy, 1'b0);
        check("mid reset done", bus.done, 1'b0);
        check("mid reset result", bus.result, 32'h0);
        last_exp = '0;

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(f3, a, b, model_res(f3, a, b), model_lat(f3, a, b),
                   $sformatf("rand%0d f3=%0d a=%08h b=%08h", i, f3, a, b), 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
